game_state_ctrl: RTL and testbench
==================================

GAME_STATE_CTRL -- requirements
Module: game_state_ctrl

Interface
REQ-001 Param BIRD_X, 10'd160, left column of the bird box (fixed).
REQ-002 Param BIRD_W, 20, bird box width in pixels.
REQ-003 Param BIRD_H, 16, bird box height in pixels.
REQ-004 Param TUBE_W, 60, tube width; a tube spans columns tube_x-TUBE_W..tube_x inclusive.
REQ-005 Param GAP_HALF, 50, half-height of the open gap centred on tube_y.
REQ-006 Param GROUND_Y, 10'd440, ground row.
REQ-007 Param HIT_TICKS, 10, clk10 cycles spent in HIT before OVER.
REQ-008 Ports: clk10 in 1, game tick; clr in 1, reset, asynchronous, active-low.
REQ-009 flap in 1, debounced synchronous button; bird_y in 10, top row of bird.
REQ-010 tube1_x_pos/tube2_x_pos/tube3_x_pos in 10 each, tube1_y_pos/tube2_y_pos/tube3_y_pos in 10 each, score in 8, all from the tube stage.
REQ-011 game_end out 1, freezes tube stage; state out 2, current FSM state; restart out 1, one-cycle pulse requesting a playfield clear.
REQ-012 best_score out 8, highest score since reset; new_best out 1, one-cycle pulse.

Function
REQ-013 States: IDLE=0, PLAY=1, HIT=2, OVER=3; state drives the output directly.
REQ-014 flap_rise = flap & ~flap_d, where flap_d is registered flap; only flap_rise advances the FSM.
REQ-015 IDLE -> PLAY on flap_rise; game_end=1 in IDLE, HIT and OVER; game_end=0 only in PLAY.
REQ-016 Tube hit (per tube) = horizontal overlap (BIRD_X+BIRD_W >= tube_x-TUBE_W and BIRD_X <= tube_x) AND (bird_y+GAP_HALF < tube_y OR bird_y+BIRD_H > tube_y+GAP_HALF).
REQ-017 All hit arithmetic is 11-bit unsigned; no subtraction of GAP_HALF from tube_y, so there is no underflow; tube_x < TUBE_W yields left edge 0.
REQ-018 Ground hit = bird_y+BIRD_H >= GROUND_Y (11-bit).
REQ-019 Hit inputs are sampled combinationally; PLAY -> HIT on the first clk10 edge where any hit is true, so the state updates one cycle after the inputs show a hit.
REQ-020 HIT loads a down-counter with HIT_TICKS-1 on entry and enters OVER on the edge where the counter is 0; flap is ignored in HIT.
REQ-021 On the PLAY->HIT edge, if score > best_score then best_score <= score and new_best=1 for that cycle; equal score does not update.
REQ-022 OVER -> IDLE on flap_rise; restart=1 for exactly the cycle after that edge.
REQ-023 Simultaneous ground hit and tube hit count as a single hit; flap_rise in the same cycle as a hit is ignored.

Reset
REQ-024 clr low, asynchronously: state=IDLE, game_end=1, restart=0, new_best=0, best_score=0, flap_d=0, counter=0.
REQ-025 clr low mid-HIT or mid-OVER aborts to IDLE with no best_score update.

Configuration
REQ-026 Macro INVINCIBLE_EN: when defined, tube hits are forced to 0 and only the ground hit ends PLAY; when undefined, REQ-016 applies fully.

Structure
REQ-027 Package flappy_pkg holds the state encoding localparams and the shared geometry defaults (TUBE_W, GAP_HALF, GROUND_Y).
REQ-028 Sub-module tube_hit_check (combinational, one tube) is instantiated three times; the FSM, counter, edge detect and best-score logic stay in the top.

Verification
REQ-029 clr low, then high, with flap=0 for 20 cycles -> state=0, game_end=1, best_score=0 throughout.
REQ-030 flap 0->1 in IDLE, bird_y=200, tubes at x=404/664/904 -> state=1 and game_end=0 on the next edge; no hit.
REQ-031 PLAY, tube1_x=200, tube1_y=240, bird_y=150 -> state=2 one cycle later; state=3 after 10 further cycles.
REQ-032 PLAY, score=7, best=0, bird_y=430 -> HIT, best_score=7, single new_best pulse; rerun with score=7 -> no pulse.
REQ-033 OVER, flap rise -> state=0 and one restart pulse; flap held high -> no second transition.
REQ-034 INVINCIBLE_EN defined, same stimulus as REQ-031 -> remains in PLAY; bird_y=430 -> HIT.

Source files
------------

// File: rtl/flappy_pkg.sv
// Shared definitions for the game control slice: FSM state encoding and
// default playfield geometry used by the hit checkers and the state control.
package flappy_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PLAY = 2'd1,
      HIT  = 2'd2,
      OVER = 2'd3
   } state_t;

   localparam int unsigned TUBE_W_DEF   = 60;
   localparam int unsigned GAP_HALF_DEF = 50;
   localparam logic [9:0]  GROUND_Y_DEF = 10'd440;

endpackage

// File: rtl/game_state_ctrl_if.sv
// Signal bundle between the tube/bird stage (master) and game_state_ctrl
// (slave): bird and tube positions plus score in, game status out.
interface game_state_ctrl_if;

   logic       flap;
   logic [9:0] bird_y;
   logic [9:0] tube1_x_pos;
   logic [9:0] tube2_x_pos;
   logic [9:0] tube3_x_pos;
   logic [9:0] tube1_y_pos;
   logic [9:0] tube2_y_pos;
   logic [9:0] tube3_y_pos;
   logic [7:0] score;
   logic       game_end;
   logic [1:0] state;
   logic       restart;
   logic [7:0] best_score;
   logic       new_best;

   modport master (
      output flap, bird_y,
      output tube1_x_pos, tube2_x_pos, tube3_x_pos,
      output tube1_y_pos, tube2_y_pos, tube3_y_pos,
      output score,
      input  game_end, state, restart, best_score, new_best
   );

   modport slave (
      input  flap, bird_y,
      input  tube1_x_pos, tube2_x_pos, tube3_x_pos,
      input  tube1_y_pos, tube2_y_pos, tube3_y_pos,
      input  score,
      output game_end, state, restart, best_score, new_best
   );

endinterface

// File: rtl/tube_hit_check.sv
// Combinational collision test between the fixed-column bird box and one tube.
// All arithmetic is 11-bit unsigned; the gap test adds to both sides instead
// of subtracting GAP_HALF from tube_y so nothing can underflow.
module tube_hit_check
   import flappy_pkg::*;
#(
   parameter logic [9:0]  BIRD_X   = 10'd160,
   parameter int unsigned BIRD_W   = 20,
   parameter int unsigned BIRD_H   = 16,
   parameter int unsigned TUBE_W   = TUBE_W_DEF,
   parameter int unsigned GAP_HALF = GAP_HALF_DEF
) (
   input  logic [9:0] bird_y,
   input  logic [9:0] tube_x,
   input  logic [9:0] tube_y,
   output logic       hit
);

   logic [10:0] bird_l, bird_r, tube_l, tube_r;
   logic [10:0] bird_gap, bird_bot, gap_bot, tube_top;
   logic        horiz, vert;

   // Overlap of column ranges, then bird outside the open gap.
   always_comb begin
      bird_l   = {1'b0, BIRD_X};
      bird_r   = {1'b0, BIRD_X} + 11'(BIRD_W);
      tube_r   = {1'b0, tube_x};
      tube_l   = ({1'b0, tube_x} < 11'(TUBE_W)) ? '0 : ({1'b0, tube_x} - 11'(TUBE_W));
      bird_gap = {1'b0, bird_y} + 11'(GAP_HALF);
      bird_bot = {1'b0, bird_y} + 11'(BIRD_H);
      tube_top = {1'b0, tube_y};
      gap_bot  = {1'b0, tube_y} + 11'(GAP_HALF);
      horiz    = (bird_r >= tube_l) && (bird_l <= tube_r);
      vert     = (bird_gap < tube_top) || (bird_bot > gap_bot);
      hit      = horiz && vert;
   end

endmodule

// File: rtl/game_state_ctrl.sv
// Game state control: IDLE/PLAY/HIT/OVER sequencing from flap edges and
// collisions, HIT dwell counter, restart pulse and best-score tracking.
// Build macro INVINCIBLE_EN: tube collisions ignored, only the ground ends PLAY.
module game_state_ctrl
   import flappy_pkg::*;
#(
   parameter logic [9:0]  BIRD_X    = 10'd160,
   parameter int unsigned BIRD_W    = 20,
   parameter int unsigned BIRD_H    = 16,
   parameter int unsigned TUBE_W    = TUBE_W_DEF,
   parameter int unsigned GAP_HALF  = GAP_HALF_DEF,
   parameter logic [9:0]  GROUND_Y  = GROUND_Y_DEF,
   parameter int unsigned HIT_TICKS = 10
) (
   input  logic            clk10,
   input  logic            clr,
   game_state_ctrl_if.slave bus
);

   localparam int unsigned   CW       = (HIT_TICKS > 2) ? $clog2(HIT_TICKS) : 1;
   localparam logic [CW-1:0] CNT_LOAD = CW'(HIT_TICKS - 1);

   state_t        state_q, state_nx;
   logic [CW-1:0] cnt_q, cnt_nx;
   logic [7:0]    best_q, best_nx;
   logic          new_best_q, new_best_nx;
   logic          restart_q, restart_nx;
   logic          flap_d;
   logic          flap_rise;
   logic [2:0]    tube_hit_raw, tube_hit;
   logic          ground_hit, any_hit;

   tube_hit_check #(
      .BIRD_X(BIRD_X), .BIRD_W(BIRD_W), .BIRD_H(BIRD_H),
      .TUBE_W(TUBE_W), .GAP_HALF(GAP_HALF)
   ) u_tube1 (
      .bird_y(bus.bird_y), .tube_x(bus.tube1_x_pos), .tube_y(bus.tube1_y_pos),
      .hit(tube_hit_raw[0])
   );

   tube_hit_check #(
      .BIRD_X(BIRD_X), .BIRD_W(BIRD_W), .BIRD_H(BIRD_H),
      .TUBE_W(TUBE_W), .GAP_HALF(GAP_HALF)
   ) u_tube2 (
      .bird_y(bus.bird_y), .tube_x(bus.tube2_x_pos), .tube_y(bus.tube2_y_pos),
      .hit(tube_hit_raw[1])
   );

   tube_hit_check #(
      .BIRD_X(BIRD_X), .BIRD_W(BIRD_W), .BIRD_H(BIRD_H),
      .TUBE_W(TUBE_W), .GAP_HALF(GAP_HALF)
   ) u_tube3 (
      .bird_y(bus.bird_y), .tube_x(bus.tube3_x_pos), .tube_y(bus.tube3_y_pos),
      .hit(tube_hit_raw[2])
   );

`ifdef INVINCIBLE_EN
   logic [2:0] unused_tube_hit;
   assign unused_tube_hit = tube_hit_raw;
   assign tube_hit        = '0;
`else
   assign tube_hit        = tube_hit_raw;
`endif

   assign ground_hit = ({1'b0, bus.bird_y} + 11'(BIRD_H)) >= {1'b0, GROUND_Y};
   assign any_hit    = ground_hit | (|tube_hit);
   assign flap_rise  = bus.flap & ~flap_d;

   // State, dwell counter, flap history and pulse registers.
   always_ff @(posedge clk10 or negedge clr) begin
      if (!clr) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         best_q     <= '0;
         new_best_q <= 1'b0;
         restart_q  <= 1'b0;
         flap_d     <= 1'b0;
      end else begin
         state_q    <= state_nx;
         cnt_q      <= cnt_nx;
         best_q     <= best_nx;
         new_best_q <= new_best_nx;
         restart_q  <= restart_nx;
         flap_d     <= bus.flap;
      end
   end

   // Next-state, counter, best-score and pulse decisions.
   always_comb begin
      state_nx    = state_q;
      cnt_nx      = cnt_q;
      best_nx     = best_q;
      new_best_nx = 1'b0;
      restart_nx  = 1'b0;
      case (state_q)
         IDLE: if (flap_rise) state_nx = PLAY;
         PLAY: begin
            if (any_hit) begin
               state_nx = HIT;
               cnt_nx   = CNT_LOAD;
               if (bus.score > best_q) begin
                  best_nx     = bus.score;
                  new_best_nx = 1'b1;
               end
            end
         end
         HIT: begin
            if (cnt_q == '0) state_nx = OVER;
            else             cnt_nx   = cnt_q - CW'(1);
         end
         OVER: begin
            if (flap_rise) begin
               state_nx   = IDLE;
               restart_nx = 1'b1;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   assign bus.state      = state_q;
   assign bus.game_end   = (state_q != PLAY);
   assign bus.restart    = restart_q;
   assign bus.new_best   = new_best_q;
   assign bus.best_score = best_q;

endmodule

// File: tb/tb_game_state_ctrl.sv
// Bench for game_state_ctrl: directed scenarios with literal expectations,
// then randomized play compared every cycle against a behavioural model.
module tb_game_state_ctrl;

   localparam int HIT_TICKS = 10;
   localparam int BIRD_X    = 160;
   localparam int BIRD_W    = 20;
   localparam int BIRD_H    = 16;
   localparam int TUBE_W    = 60;
   localparam int GAP_HALF  = 50;
   localparam int GROUND_Y  = 440;

   logic clk10 = 1'b0;
   logic clr;
   always #5 clk10 = ~clk10;

   game_state_ctrl_if bus ();

   game_state_ctrl #(
      .BIRD_X(10'd160), .BIRD_W(20), .BIRD_H(16), .TUBE_W(60),
      .GAP_HALF(50), .GROUND_Y(10'd440), .HIT_TICKS(10)
   ) dut (
      .clk10(clk10),
      .clr(clr),
      .bus(bus)
   );

   // Behavioural model state (state numbers are the visible output codes)
   int m_state, m_hit_left, m_best, m_new_best, m_restart, m_flap_prev;

   int n_pass  = 0;
   int n_total = 0;
   int cmp_en  = 0;

   string pin_name [4];
   int    pin_sig  [4];
   int    pin_val  [4];
   int    pin_cnt  = 0;
   int    pin_seq  = 0;
   int    pin_done = 0;

   function automatic int tube_hits(int tx, int ty, int by);
      int left;
      left = (tx < TUBE_W) ? 0 : tx - TUBE_W;
      return int'((BIRD_X + BIRD_W >= left) && (BIRD_X <= tx) &&
                  ((by + GAP_HALF < ty) || (by + BIRD_H > ty + GAP_HALF)));
   endfunction

   function automatic int any_hit_model();
      int by, h;
      by = int'(bus.bird_y);
      h  = int'(by + BIRD_H >= GROUND_Y);
`ifndef INVINCIBLE_EN
      h = h | tube_hits(int'(bus.tube1_x_pos), int'(bus.tube1_y_pos), by)
            | tube_hits(int'(bus.tube2_x_pos), int'(bus.tube2_y_pos), by)
            | tube_hits(int'(bus.tube3_x_pos), int'(bus.tube3_y_pos), by);
`endif
      return h;
   endfunction

   // Model: advances on each clock edge, resets whenever clr is low.
   initial begin
      m_state = 0; m_hit_left = 0; m_best = 0;
      m_new_best = 0; m_restart = 0; m_flap_prev = 0;
      forever begin
         @(posedge clk10 or negedge clr);
         if (clr !== 1'b1) begin
            m_state = 0; m_hit_left = 0; m_best = 0;
            m_new_best = 0; m_restart = 0; m_flap_prev = 0;
         end else begin
            int rise, hit;
            rise        = int'(bus.flap) & (1 - m_flap_prev);
            m_flap_prev = int'(bus.flap);
            hit         = any_hit_model();
            m_new_best  = 0;
            m_restart   = 0;
            if (m_state == 0) begin
               if (rise != 0) m_state = 1;
            end else if (m_state == 1) begin
               if (hit != 0) begin
                  m_state    = 2;
                  m_hit_left = HIT_TICKS;
                  if (int'(bus.score) > m_best) begin
                     m_best     = int'(bus.score);
                     m_new_best = 1;
                  end
               end
            end else if (m_state == 2) begin
               m_hit_left = m_hit_left - 1;
               if (m_hit_left == 0) m_state = 3;
            end else begin
               if (rise != 0) begin
                  m_state   = 0;
                  m_restart = 1;
               end
            end
         end
      end
   end

   task automatic check(string name, int act, int exp);
      n_total = n_total + 1;
      if (act == exp) n_pass = n_pass + 1;
      else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
   endtask

   function automatic int dut_sig(int k);
      case (k)
         0: return int'(bus.state);
         1: return int'(bus.game_end);
         2: return int'(bus.best_score);
         3: return int'(bus.restart);
         default: return int'(bus.new_best);
      endcase
   endfunction

   function automatic int model_sig(int k);
      case (k)
         0: return m_state;
         1: return int'(m_state != 1);
         2: return m_best;
         3: return m_restart;
         default: return m_new_best;
      endcase
   endfunction

   // Compare process: every falling edge, DUT vs model, plus pending literal pins.
   initial forever begin
      @(negedge clk10);
      if (cmp_en != 0) begin
         for (int k = 0; k < 5; k++) begin
            string nm;
            case (k)
               0: nm = "state";
               1: nm = "game_end";
               2: nm = "best_score";
               3: nm = "restart";
               default: nm = "new_best";
            endcase
            check(nm, dut_sig(k), model_sig(k));
         end
         if (pin_seq != pin_done) begin
            pin_done = pin_seq;
            for (int i = 0; i < pin_cnt; i++) begin
               check({pin_name[i], "_dut"},   dut_sig(pin_sig[i]),   pin_val[i]);
               check({pin_name[i], "_model"}, model_sig(pin_sig[i]), pin_val[i]);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk10);
      #2;
   endtask

   task automatic pin(string name, int sig, int val);
      pin_name[pin_cnt] = name;
      pin_sig[pin_cnt]  = sig;
      pin_val[pin_cnt]  = val;
      pin_cnt = pin_cnt + 1;
   endtask

   task automatic pin_go();
      pin_seq = pin_seq + 1;
      @(negedge clk10);
      #1;
      pin_cnt = 0;
   endtask

   task automatic tubes_far();
      bus.tube1_x_pos = 10'd404; bus.tube1_y_pos = 10'd240;
      bus.tube2_x_pos = 10'd664; bus.tube2_y_pos = 10'd240;
      bus.tube3_x_pos = 10'd904; bus.tube3_y_pos = 10'd240;
   endtask

   initial begin
      clr = 1'b1;
      bus.flap = 1'b0; bus.bird_y = 10'd200; bus.score = 8'd0;
      tubes_far();
      #1 clr = 1'b0;
      cmp_en = 1;
      repeat (3) tick();
      clr = 1'b1;

      // Idle with flap low
      repeat (20) tick();
      pin("idle_state", 0, 0); pin("idle_game_end", 1, 1); pin("idle_best", 2, 0);
      pin_go();

      // Start play, no collisions
      bus.flap = 1'b1;
      tick();
      pin("start_state", 0, 1); pin("start_game_end", 1, 0);
      pin_go();
      bus.flap = 1'b0;
      repeat (3) tick();

      // Tube collision, then HIT dwell
      bus.tube1_x_pos = 10'd200; bus.tube1_y_pos = 10'd240; bus.bird_y = 10'd150;
      tick();
`ifdef INVINCIBLE_EN
      pin("invincible_play", 0, 1);
      pin_go();
      bus.bird_y = 10'd430;
      tick();
`endif
      pin("hit_state", 0, 2); pin("hit_no_new_best", 4, 0);
      pin_go();
      tubes_far(); bus.bird_y = 10'd200;
      repeat (9) tick();
      pin("hit_dwell", 0, 2);
      pin_go();
      tick();
      pin("over_state", 0, 3); pin("over_game_end", 1, 1);
      pin_go();

      // Restart, flap held
      bus.flap = 1'b1;
      tick();
      pin("restart_state", 0, 0); pin("restart_pulse", 3, 1);
      pin_go();
      repeat (4) tick();
      pin("held_state", 0, 0); pin("held_restart", 3, 0);
      pin_go();
      bus.flap = 1'b0;
      tick();

      // Ground hit with new best
      bus.flap = 1'b1; tick(); bus.flap = 1'b0;
      bus.score = 8'd7; bus.bird_y = 10'd430;
      tick();
      pin("ground_state", 0, 2); pin("best7", 2, 7); pin("new_best_pulse", 4, 1);
      pin_go();
      tick();
      pin("new_best_single", 4, 0);
      pin_go();
      bus.bird_y = 10'd200;
      repeat (10) tick();
      bus.flap = 1'b1; tick(); bus.flap = 1'b0; tick();
      bus.flap = 1'b1; tick(); bus.flap = 1'b0;
      bus.bird_y = 10'd430;
      tick();
      pin("equal_state", 0, 2); pin("equal_best", 2, 7); pin("equal_no_pulse", 4, 0);
      pin_go();

      // Ground boundary: 423+16 misses, 424+16 hits
      bus.bird_y = 10'd200;
      repeat (12) tick();
      bus.flap = 1'b1; tick(); bus.flap = 1'b0; tick();
      bus.flap = 1'b1; tick(); bus.flap = 1'b0;
      bus.bird_y = 10'd423;
      tick(); tick();
      pin("ground_423", 0, 1);
      pin_go();
      bus.bird_y = 10'd424;
      tick();
      pin("ground_424", 0, 2);
      pin_go();

      // Reset mid-HIT
      bus.bird_y = 10'd200;
      tick();
      clr = 1'b0;
      pin("abort_state", 0, 0); pin("abort_best", 2, 0);
      pin_go();
      tick();
      clr = 1'b1;
      tick();

      // Randomized play
      for (int n = 0; n < 3000; n++) begin
         int by;
         bus.flap  = 1'($urandom_range(0, 1));
         by        = int'($urandom_range(0, 445));
         bus.bird_y = 10'(by);
         bus.score = 8'($urandom_range(0, 255));
         bus.tube1_x_pos = 10'($urandom_range(0, 1023));
         bus.tube2_x_pos = 10'($urandom_range(100, 300));
         bus.tube3_x_pos = 10'($urandom_range(0, 80));
         bus.tube1_y_pos = 10'($urandom_range(0, 1023));
         bus.tube2_y_pos = 10'(by + int'($urandom_range(0, 110)));
         bus.tube3_y_pos = 10'($urandom_range(0, 600));
         if ($urandom_range(0, 299) == 0) clr = 1'b0;
         else clr = 1'b1;
         tick();
      end
      clr = 1'b1;
      repeat (2) tick();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
